msrh_rs_scheduler: RTL and testbench

//  Arithmetic reservation-station scheduler between rename/dispatch and the ALU pipes.

---
 rtl/msrh_rs_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_msrh_rs_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_rs_scheduler.sv
// msrh_rs_scheduler
//   Arithmetic reservation station for one ALU pipe. It buffers renamed ops,
//   tracks rs1/rs2 readiness by snooping the early-wakeup bus, and each cycle
//   offers the oldest fully-ready entry (age matrix) to the ALU.
//
// Ports
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_disp_valid       per-slot dispatch valid
//   i_disp             per-slot renamed op word (layout below)
//   i_disp_cmt_id      ROB block id shared by the dispatch group
//   i_disp_grp_id      one-hot group position per slot
//   o_disp_ready       group can be accepted this cycle
//   i_early_wr         wakeup ports: {valid, rd_type, rd_rnid}
//   o_issue_valid      selected op valid
//   o_issue            selected op word with stored ready bits
//   o_issue_cmt_id     selected op ROB block id
//   o_issue_grp_id     selected op group id
//   i_issue_stall      ALU cannot take the op this cycle
//   i_flush            drop every entry plus this cycle's dispatch and issue
//   o_count            occupied entries
//
// Op word layout, LSB first (SRC_W = RNID_W + 3 bits per source):
//   rs2_ready, rs2_rnid[RNID_W], rs2_type, rs2_valid,
//   rs1_ready, rs1_rnid[RNID_W], rs1_type, rs1_valid, inst[INST_W]
module msrh_rs_scheduler #(
   parameter int ENTRY_SIZE = 32,
   parameter int IN_PORT    = 4,
   parameter int WAKE_NUM   = 4,
   parameter int CMT_BLK_W  = 5,
   parameter int DISP_SIZE  = 4,
   parameter int RNID_W     = 6,
   parameter int INST_W     = 32,
   localparam int SRC_W     = RNID_W + 3,
   localparam int DISP_W    = INST_W + 2 * SRC_W,
   localparam int WAKE_W    = RNID_W + 2,
   localparam int CNT_W     = $clog2(ENTRY_SIZE + 1)
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset_n,
   input  logic [IN_PORT-1:0]                   i_disp_valid,
   input  logic [IN_PORT-1:0][DISP_W-1:0]       i_disp,
   input  logic [CMT_BLK_W-1:0]                 i_disp_cmt_id,
   input  logic [IN_PORT-1:0][DISP_SIZE-1:0]    i_disp_grp_id,
   output logic                                 o_disp_ready,
   input  logic [WAKE_NUM-1:0][WAKE_W-1:0]      i_early_wr,
   output logic                                 o_issue_valid,
   output logic [DISP_W-1:0]                    o_issue,
   output logic [CMT_BLK_W-1:0]                 o_issue_cmt_id,
   output logic [DISP_SIZE-1:0]                 o_issue_grp_id,
   input  logic                                 i_issue_stall,
   input  logic                                 i_flush,
   output logic [CNT_W-1:0]                     o_count
);

   localparam int IDX_W   = $clog2(ENTRY_SIZE);
   localparam int RS2_RDY = 0;
   localparam int RS2_TYP = RNID_W + 1;
   localparam int RS2_VLD = RNID_W + 2;
   localparam int RS1_RDY = SRC_W;
   localparam int RS1_TYP = SRC_W + RNID_W + 1;
   localparam int RS1_VLD = SRC_W + RNID_W + 2;

   logic [ENTRY_SIZE-1:0] valid_r, valid_nxt;
   logic [DISP_W-1:0]     entry_r [ENTRY_SIZE];
   logic [DISP_W-1:0]     entry_nxt [ENTRY_SIZE];
   logic [CMT_BLK_W-1:0]  cmt_r [ENTRY_SIZE];
   logic [CMT_BLK_W-1:0]  cmt_nxt [ENTRY_SIZE];
   logic [DISP_SIZE-1:0]  grp_r [ENTRY_SIZE];
   logic [DISP_SIZE-1:0]  grp_nxt [ENTRY_SIZE];
   logic [ENTRY_SIZE-1:0] age_r [ENTRY_SIZE];   // age_r[i][j]: i older than j
   logic [ENTRY_SIZE-1:0] age_nxt [ENTRY_SIZE];
   logic [IDX_W-1:0]      slot_idx [IN_PORT];
   logic [ENTRY_SIZE-1:0] cand, pick_oh;
   logic [IDX_W-1:0]      pick_idx;
   logic                  disp_ready_r;
   logic [CNT_W-1:0]      count_r;
   logic                  disp_fire, issue_fire;

   function automatic logic wake_hit(input logic [WAKE_NUM-1:0][WAKE_W-1:0] wr,
                                     input logic [RNID_W-1:0] rnid, input logic typ);
      wake_hit = 1'b0;
      for (int w = 0; w < WAKE_NUM; w++) begin
         if (wr[w][WAKE_W-1] && (wr[w][RNID_W] == typ) && (wr[w][RNID_W-1:0] == rnid)) begin
            wake_hit = 1'b1;
         end else begin
            wake_hit = wake_hit;
         end
      end
   endfunction

   // Dispatch-time ready: already ready, no such source, or woken this very cycle.
   function automatic logic [DISP_W-1:0] init_entry(input logic [DISP_W-1:0] d,
                                                    input logic [WAKE_NUM-1:0][WAKE_W-1:0] wr);
      init_entry = d;
      init_entry[RS1_RDY] = d[RS1_RDY] | ~d[RS1_VLD] | wake_hit(wr, d[RS1_RDY+RNID_W:RS1_RDY+1], d[RS1_TYP]);
      init_entry[RS2_RDY] = d[RS2_RDY] | ~d[RS2_VLD] | wake_hit(wr, d[RS2_RDY+RNID_W:RS2_RDY+1], d[RS2_TYP]);
   endfunction

   function automatic logic [CNT_W-1:0] pop(input logic [ENTRY_SIZE-1:0] v);
      pop = '0;
      for (int i = 0; i < ENTRY_SIZE; i++) pop = pop + CNT_W'(v[i]);
   endfunction

   // Slot k is assigned the k-th lowest free entry index.
   always_comb begin
      int n;
      n = 0;
      for (int k = 0; k < IN_PORT; k++) slot_idx[k] = '0;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         if (!valid_r[i] && (n < IN_PORT)) begin
            slot_idx[n] = IDX_W'(i);
            n = n + 1;
         end else begin
            n = n;
         end
      end
   end

   // Oldest-ready select: a candidate wins when no other candidate is older.
   always_comb begin
      logic blocked;
      pick_idx = '0;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         cand[i] = valid_r[i] & entry_r[i][RS1_RDY] & entry_r[i][RS2_RDY];
      end
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < ENTRY_SIZE; j++) blocked = blocked | (cand[j] & age_r[j][i]);
         pick_oh[i] = cand[i] & ~blocked;
      end
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         if (pick_oh[i]) begin
            pick_idx = IDX_W'(i);
         end else begin
            pick_idx = pick_idx;
         end
      end
   end

   assign disp_fire      = disp_ready_r & ~i_flush;
   assign issue_fire     = o_issue_valid & ~i_issue_stall;
   assign o_issue_valid  = (|cand) & ~i_flush;
   assign o_issue        = (|cand) ? entry_r[pick_idx] : {DISP_W{1'b0}};
   assign o_issue_cmt_id = (|cand) ? cmt_r[pick_idx] : {CMT_BLK_W{1'b0}};
   assign o_issue_grp_id = (|cand) ? grp_r[pick_idx] : {DISP_SIZE{1'b0}};
   assign o_disp_ready   = disp_ready_r;
   assign o_count        = count_r;

   // Next-state: wakeup snoop, issue release, allocation with age ordering, flush.
   always_comb begin
      valid_nxt = valid_r;
      entry_nxt = entry_r;
      cmt_nxt   = cmt_r;
      grp_nxt   = grp_r;
      age_nxt   = age_r;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
         if (valid_r[i]) begin
            entry_nxt[i][RS1_RDY] = entry_r[i][RS1_RDY] |
               wake_hit(i_early_wr, entry_r[i][RS1_RDY+RNID_W:RS1_RDY+1], entry_r[i][RS1_TYP]);
            entry_nxt[i][RS2_RDY] = entry_r[i][RS2_RDY] |
               wake_hit(i_early_wr, entry_r[i][RS2_RDY+RNID_W:RS2_RDY+1], entry_r[i][RS2_TYP]);
         end else begin
            entry_nxt[i] = entry_r[i];
         end
      end
      if (issue_fire) begin
         valid_nxt[pick_idx] = 1'b0;
      end else begin
         valid_nxt = valid_nxt;
      end
      if (disp_fire) begin
         for (int k = 0; k < IN_PORT; k++) begin
            if (i_disp_valid[k]) begin
               valid_nxt[slot_idx[k]] = 1'b1;
               entry_nxt[slot_idx[k]] = init_entry(i_disp[k], i_early_wr);
               cmt_nxt[slot_idx[k]]   = i_disp_cmt_id;
               grp_nxt[slot_idx[k]]   = i_disp_grp_id[k];
               age_nxt[slot_idx[k]]   = '0;
               // Every resident entry is older than the newcomer.
               for (int r = 0; r < ENTRY_SIZE; r++) age_nxt[r][slot_idx[k]] = valid_r[r];
               // Lower dispatch slots in the same group are older.
               for (int m = 0; m < k; m++) begin
                  if (i_disp_valid[m]) begin
                     age_nxt[slot_idx[m]][slot_idx[k]] = 1'b1;
                  end else begin
                     age_nxt[slot_idx[m]][slot_idx[k]] = age_nxt[slot_idx[m]][slot_idx[k]];
                  end
               end
            end else begin
               valid_nxt = valid_nxt;
            end
         end
      end else begin
         valid_nxt = valid_nxt;
      end
      if (i_flush) begin
         valid_nxt = '0;
      end else begin
         valid_nxt = valid_nxt;
      end
   end

   // State registers; count and dispatch-ready are registered from the next valid set.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_r      <= '0;
         entry_r      <= '{default: '0};
         cmt_r        <= '{default: '0};
         grp_r        <= '{default: '0};
         age_r        <= '{default: '0};
         count_r      <= '0;
         disp_ready_r <= 1'b1;
      end else begin
         valid_r      <= valid_nxt;
         entry_r      <= entry_nxt;
         cmt_r        <= cmt_nxt;
         grp_r        <= grp_nxt;
         age_r        <= age_nxt;
         count_r      <= pop(valid_nxt);
         disp_ready_r <= ((CNT_W'(ENTRY_SIZE) - pop(valid_nxt)) >= CNT_W'(IN_PORT));
      end
   end

endmodule

// File: tb/tb_msrh_rs_scheduler.sv
// tb_msrh_rs_scheduler
//   Directed bench for msrh_rs_scheduler: reset, single-op issue with stall,
//   delayed and same-cycle wakeup, in-group age order, full station, flush.
module tb_msrh_rs_scheduler;

   logic                 i_clk;
   logic                 i_reset_n;
   logic [3:0]           i_disp_valid;
   logic [3:0][49:0]     i_disp;
   logic [4:0]           i_disp_cmt_id;
   logic [3:0][3:0]      i_disp_grp_id;
   logic                 o_disp_ready;
   logic [3:0][7:0]      i_early_wr;
   logic                 o_issue_valid;
   logic [49:0]          o_issue;
   logic [4:0]           o_issue_cmt_id;
   logic [3:0]           o_issue_grp_id;
   logic                 i_issue_stall;
   logic                 i_flush;
   logic [5:0]           o_count;

   int n_chk;
   int n_pass;

   msrh_rs_scheduler dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_disp_valid   (i_disp_valid),
      .i_disp         (i_disp),
      .i_disp_cmt_id  (i_disp_cmt_id),
      .i_disp_grp_id  (i_disp_grp_id),
      .o_disp_ready   (o_disp_ready),
      .i_early_wr     (i_early_wr),
      .o_issue_valid  (o_issue_valid),
      .o_issue        (o_issue),
      .o_issue_cmt_id (o_issue_cmt_id),
      .o_issue_grp_id (o_issue_grp_id),
      .i_issue_stall  (i_issue_stall),
      .i_flush        (i_flush),
      .o_count        (o_count)
   );

   // Free-running clock, period 10.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic logic [49:0] mk(input logic [31:0] inst,
                                      input logic v1, input logic [5:0] n1, input logic r1,
                                      input logic v2, input logic [5:0] n2, input logic r2);
      mk = {inst, v1, 1'b0, n1, r1, v2, 1'b0, n2, r2};
   endfunction

   function automatic logic [7:0] wk(input logic [5:0] rnid);
      wk = {1'b1, 1'b0, rnid};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic idle();
      i_disp_valid  = 4'b0000;
      i_disp        = '0;
      i_disp_cmt_id = 5'd0;
      i_disp_grp_id = '0;
      i_early_wr    = '0;
      i_issue_stall = 1'b0;
      i_flush       = 1'b0;
   endtask

   // Advance through one rising edge; inputs may be changed afterwards.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      idle();
      i_reset_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      #1;
      chk("rst_issue_valid", 64'(o_issue_valid), 64'd0);
      chk("rst_count", 64'(o_count), 64'd0);
      chk("rst_disp_ready", 64'(o_disp_ready), 64'd1);
      chk("rst_issue_cmt", 64'(o_issue_cmt_id), 64'd0);

      // Single ready op, stalled two cycles, then released.
      i_disp_valid     = 4'b0001;
      i_disp[0]        = mk(32'hAAAA0001, 1'b1, 6'h01, 1'b1, 1'b1, 6'h02, 1'b1);
      i_disp_cmt_id    = 5'd5;
      i_disp_grp_id[0] = 4'b0001;
      cyc();
      idle();
      i_issue_stall = 1'b1;
      #1;
      chk("one_valid", 64'(o_issue_valid), 64'd1);
      chk("one_cmt", 64'(o_issue_cmt_id), 64'd5);
      chk("one_payload", 64'(o_issue), 64'(mk(32'hAAAA0001, 1'b1, 6'h01, 1'b1, 1'b1, 6'h02, 1'b1)));
      chk("one_count", 64'(o_count), 64'd1);
      for (int s = 0; s < 2; s++) begin
         cyc();
         #1;
         chk("stall_valid", 64'(o_issue_valid), 64'd1);
         chk("stall_cmt", 64'(o_issue_cmt_id), 64'd5);
         chk("stall_count", 64'(o_count), 64'd1);
      end
      i_issue_stall = 1'b0;
      cyc();
      #1;
      chk("release_count", 64'(o_count), 64'd0);
      chk("release_valid", 64'(o_issue_valid), 64'd0);

      // rs1 waits on rnid 0x12; unrelated wakeup first, real wakeup three cycles later.
      i_disp_valid     = 4'b0001;
      i_disp[0]        = mk(32'h00000003, 1'b1, 6'h12, 1'b0, 1'b0, 6'h00, 1'b0);
      i_disp_grp_id[0] = 4'b0001;
      cyc();
      idle();
      #1;
      chk("wait_count", 64'(o_count), 64'd1);
      chk("wait_valid0", 64'(o_issue_valid), 64'd0);
      i_early_wr[0] = wk(6'h13);
      cyc();
      idle();
      #1;
      chk("wake_other", 64'(o_issue_valid), 64'd0);
      cyc();
      #1;
      chk("wait_valid2", 64'(o_issue_valid), 64'd0);
      i_early_wr[1] = wk(6'h12);
      cyc();
      idle();
      #1;
      chk("wake_valid", 64'(o_issue_valid), 64'd1);
      chk("wake_payload", 64'(o_issue), 64'(mk(32'h00000003, 1'b1, 6'h12, 1'b1, 1'b0, 6'h00, 1'b1)));
      cyc();
      #1;
      chk("wake_drain", 64'(o_count), 64'd0);

      // Wakeup in the same cycle as dispatch.
      i_disp_valid     = 4'b0001;
      i_disp[0]        = mk(32'h00000004, 1'b0, 6'h00, 1'b0, 1'b1, 6'h15, 1'b0);
      i_disp_grp_id[0] = 4'b0001;
      i_early_wr[2]    = wk(6'h15);
      cyc();
      idle();
      #1;
      chk("same_wake_valid", 64'(o_issue_valid), 64'd1);
      chk("same_wake_payload", 64'(o_issue), 64'(mk(32'h00000004, 1'b0, 6'h00, 1'b1, 1'b1, 6'h15, 1'b1)));
      cyc();
      #1;
      chk("same_wake_drain", 64'(o_count), 64'd0);

      // Four ready ops in one group issue in slot order.
      i_disp_valid  = 4'b1111;
      i_disp_cmt_id = 5'd7;
      for (int k = 0; k < 4; k++) begin
         i_disp[k]        = mk(32'h10 + 32'(k), 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
         i_disp_grp_id[k] = 4'(1 << k);
      end
      cyc();
      idle();
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("grp_order", 64'(o_issue_grp_id), 64'(1 << k));
         chk("grp_count", 64'(o_count), 64'(4 - k));
         chk("grp_cmt", 64'(o_issue_cmt_id), 64'd7);
         cyc();
         #1;
      end
      chk("grp_empty", 64'(o_count), 64'd0);
      chk("grp_empty_valid", 64'(o_issue_valid), 64'd0);

      // Fill to 29 waiting entries; rnid of entry n is 0x20+n.
      for (int g = 0; g < 8; g++) begin
         if (g == 7) chk("fill28_ready", 64'(o_disp_ready), 64'd1);
         i_disp_valid = (g == 7) ? 4'b0001 : 4'b1111;
         for (int k = 0; k < 4; k++) begin
            i_disp[k]        = mk(32'h100 + 32'(g * 4 + k), 1'b1, 6'(32 + g * 4 + k), 1'b0, 1'b0, 6'h00, 1'b0);
            i_disp_grp_id[k] = 4'(1 << k);
         end
         cyc();
         idle();
      end
      #1;
      chk("full_count", 64'(o_count), 64'd29);
      chk("full_ready", 64'(o_disp_ready), 64'd0);
      chk("full_valid", 64'(o_issue_valid), 64'd0);
      i_disp_valid = 4'b0001;
      i_disp[0]    = mk(32'hDEAD, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
      cyc();
      idle();
      #1;
      chk("full_reject_count", 64'(o_count), 64'd29);
      chk("full_reject_valid", 64'(o_issue_valid), 64'd0);
      i_early_wr[3] = wk(6'h20);
      cyc();
      idle();
      #1;
      chk("full_wake_valid", 64'(o_issue_valid), 64'd1);
      chk("full_wake_inst", 64'(o_issue[49:18]), 64'h100);
      cyc();
      #1;
      chk("full_after_count", 64'(o_count), 64'd28);
      chk("full_after_ready", 64'(o_disp_ready), 64'd1);

      // Flush suppresses a pending issue and clears the station.
      i_disp_valid = 4'b0001;
      i_disp[0]    = mk(32'h200, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
      cyc();
      idle();
      #1;
      chk("pre_flush_valid", 64'(o_issue_valid), 64'd1);
      chk("pre_flush_count", 64'(o_count), 64'd29);
      i_flush = 1'b1;
      #1;
      chk("flush_gates_issue", 64'(o_issue_valid), 64'd0);
      cyc();
      idle();
      #1;
      chk("flush1_count", 64'(o_count), 64'd0);

      // 20 waiting entries, then flush together with a ready dispatch group.
      for (int g = 0; g < 5; g++) begin
         i_disp_valid = 4'b1111;
         for (int k = 0; k < 4; k++) begin
            i_disp[k]        = mk(32'h300 + 32'(g * 4 + k), 1'b1, 6'(g * 4 + k), 1'b0, 1'b0, 6'h00, 1'b0);
            i_disp_grp_id[k] = 4'(1 << k);
         end
         cyc();
         idle();
      end
      #1;
      chk("fill20_count", 64'(o_count), 64'd20);
      i_flush      = 1'b1;
      i_disp_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         i_disp[k]        = mk(32'h400 + 32'(k), 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b1);
         i_disp_grp_id[k] = 4'(1 << k);
      end
      cyc();
      idle();
      #1;
      chk("flush2_count", 64'(o_count), 64'd0);
      chk("flush2_valid", 64'(o_issue_valid), 64'd0);
      chk("flush2_ready", 64'(o_disp_ready), 64'd1);
      cyc();
      #1;
      chk("flush2_dropped", 64'(o_issue_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
